// File: rtl/jcpu_pkg.sv
// Shared definitions for the jcpu stepper: phase encodings and default sizes.
package jcpu_pkg;

   typedef enum logic [1:0] {
      P0 = 2'd0,
      P1 = 2'd1,
      P2 = 2'd2,
      P3 = 2'd3
   } phase_t;

   localparam int NSTEPS_DEF = 6;
   localparam int NCNT_DEF   = 8;

endpackage

// File: rtl/jphase.sv
// Four-phase counter generating the bus-enable window (P1,P2) and register set pulse (P2).
module jphase
   import jcpu_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic halt,
   input  logic adv,
   output logic clke,
   output logic clks,
   output logic tick
);

   phase_t phase, phase_nxt;
   logic   clke_nxt, clks_nxt;

   // tick marks the edge on which P3 rolls over to P0
   assign tick = (phase == P3) && !halt && adv;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         phase <= P0;
         clke  <= 1'b0;
         clks  <= 1'b0;
      end else begin
         phase <= phase_nxt;
         clke  <= clke_nxt;
         clks  <= clks_nxt;
      end
   end

   always_comb begin
      phase_nxt = phase;
      clke_nxt  = 1'b0;
      clks_nxt  = 1'b0;
      if (!halt) begin
         if (phase != P3 || adv)
            phase_nxt = phase_t'(phase + 2'd1);
         // outputs are registered from the next phase so they align with it
         clke_nxt = (phase_nxt == P1) || (phase_nxt == P2);
         clks_nxt = (phase_nxt == P2);
      end
   end

endmodule

// File: rtl/jstepper.sv
// One-hot instruction stepper with early-end request, halt and completed-instruction counter.
// Define JSTEPPER_SINGLE_STEP_EN to add wadvance, which gates every P3->P0 transition.
module jstepper
   import jcpu_pkg::*;
#(
   parameter int NSTEPS = NSTEPS_DEF,
   parameter int NCNT   = NCNT_DEF
) (
   input  logic              wclk,
   input  logic              wreset_n,
   input  logic              whalt,
   input  logic              wstep_rst,
`ifdef JSTEPPER_SINGLE_STEP_EN
   input  logic              wadvance,
`endif
   output logic [NSTEPS-1:0] bos,
   output logic              wclke,
   output logic              wclks,
   output logic              wdone,
   output logic [NCNT-1:0]   bcount
);

   logic adv;
   logic tick;
   logic pend;
   logic wrap;

`ifdef JSTEPPER_SINGLE_STEP_EN
   assign adv = wadvance;
`else
   assign adv = 1'b1;
`endif

   jphase u_phase (
      .clk   (wclk),
      .rst_n (wreset_n),
      .halt  (whalt),
      .adv   (adv),
      .clke  (wclke),
      .clks  (wclks),
      .tick  (tick)
   );

   // a request arriving on the rollover edge itself ends this instruction
   assign wrap = tick && (pend || wstep_rst || bos[NSTEPS-1]);

   always_ff @(posedge wclk) begin
      if (!wreset_n) begin
         bos    <= {{(NSTEPS-1){1'b0}}, 1'b1};
         pend   <= 1'b0;
         wdone  <= 1'b0;
         bcount <= '0;
      end else begin
         wdone <= wrap;
         if (tick) begin
            bos  <= wrap ? {{(NSTEPS-1){1'b0}}, 1'b1} : {bos[NSTEPS-2:0], 1'b0};
            pend <= 1'b0;
         end else begin
            pend <= pend || wstep_rst;
         end
         if (wrap)
            bcount <= bcount + {{(NCNT-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: doc/jstepper.md
JSTEPPER -- requirements
Module: jstepper

Interface
REQ-001 SHALL declare parameter NSTEPS, default 6, number of one-hot instruction steps.
REQ-002 SHALL declare parameter NCNT, default 8, width of the completed-instruction counter.
REQ-003 SHALL have port wclk, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port wreset_n, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have port whalt, input, 1, freezes phase and step while high.
REQ-006 SHALL have port wstep_rst, input, 1, requests early end of the current instruction.
REQ-007 SHALL have port bos, output, NSTEPS, one-hot current step; bos[0] = step 1.
REQ-008 SHALL have port wclke, output, 1, enable window for bus drivers.
REQ-009 SHALL have port wclks, output, 1, set pulse for registers; always inside the wclke window.
REQ-010 SHALL have port wdone, output, 1, one-cycle pulse marking instruction completion.
REQ-011 SHALL have port bcount, output, NCNT, count of completed instructions.

Function
REQ-012 SHALL run a 2-bit phase counter P0->P1->P2->P3->P0, advancing once per wclk when not halted.
REQ-013 SHALL assert wclke, registered, in phases P1 and P2 only.
REQ-014 SHALL assert wclks, registered, in phase P2 only, so the set pulse never leads or trails enable.
REQ-015 SHALL advance bos one position on each P3->P0 transition; one step lasts exactly 4 wclk cycles.
REQ-016 SHALL wrap from step NSTEPS to step 1 on the P3->P0 transition, pulse wdone in that cycle, and increment bcount.
REQ-017 SHALL wrap bcount modulo 2^NCNT with no saturation or flag.
REQ-018 SHALL latch wstep_rst when sampled high in any phase into a pending flag.
REQ-019 SHALL, with the flag set at the next P3->P0 transition, go to step 1, pulse wdone, increment bcount, and clear the flag.
REQ-020 SHALL treat wstep_rst sampled during step NSTEPS as a normal wrap, producing one wdone only.
REQ-021 SHALL hold phase, bos, bcount and the pending flag while whalt is high, force wclke, wclks and wdone to 0, and resume from the frozen phase one cycle after whalt falls.
REQ-022 SHALL latch wstep_rst if it is high while whalt is high, and apply it per REQ-019 after release.
REQ-023 SHALL keep bos exactly one-hot at all times after reset.

Reset
REQ-024 SHALL, when wreset_n is sampled low, set bos = 1 (step 1), phase = P0, wclke = 0, wclks = 0, wdone = 0, bcount = 0, and clear the pending flag.
REQ-025 SHALL give reset priority over whalt and wstep_rst; reset mid-step discards the partial step.

Configuration
REQ-026 SHALL provide macro JSTEPPER_SINGLE_STEP_EN, which adds input wadvance, 1 bit.
REQ-027 SHALL, with JSTEPPER_SINGLE_STEP_EN defined, hold in P3 until wadvance is sampled high, then take the P3->P0 transition, so there is one step per wadvance pulse.
REQ-028 SHALL, without JSTEPPER_SINGLE_STEP_EN, omit wadvance and run freely per REQ-012.

Structure
REQ-029 SHALL place the phase encodings P0..P3, the default NSTEPS and the default NCNT in a shared package jcpu_pkg.
REQ-030 SHALL implement phase counting and wclke/wclks generation in sub-module jphase.
REQ-031 SHALL implement the step ring, the pending flag and bcount in jstepper, built from the basic gate library where practical.

Verification
REQ-032 Free run after reset: after 24 cycles bos = 000001, bcount = 1, exactly one wdone pulse, wclke high 12 cycles, wclks high 6 cycles.
REQ-033 Pulse wstep_rst for 1 cycle in step 3, phase P1: next step is step 1 at the following P3->P0 transition, and bcount increments by exactly 1.
REQ-034 Raise whalt in step 2, phase P2, for 10 cycles: bos and phase are frozen, wclke = wclks = 0, and P3 follows 1 cycle after release.
REQ-035 Drop wreset_n for 1 cycle in step 5, phase P3: the next cycle shows step 1, P0, bcount = 0, no wdone.
REQ-036 Preload bcount to 255 via 255 instructions, then complete one more: bcount = 0 and wdone pulses once.
REQ-037 With JSTEPPER_SINGLE_STEP_EN defined and wadvance low: hold in P3 for 20 cycles; one wadvance pulse advances exactly one step.
